// File: rtl/uart_rx.sv
// uart_rx: 8-bit UART receiver (LSB first, one parity bit, one stop bit) with strobe and error flag.
module uart_rx #(
    parameter int   CLK_FREQUENCY = 100_000_000,
    parameter int   BAUD_RATE     = 19_200,
    parameter logic PARITY        = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       din,
    output logic [7:0] dout,
    output logic       busy,
    output logic       data_strobe,
    output logic       rx_error
);
    localparam int BAUD_CLOCKS = CLK_FREQUENCY / BAUD_RATE;
    localparam int HALF_CLOCKS = BAUD_CLOCKS / 2;
    localparam int CW          = $clog2(BAUD_CLOCKS);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [2:0]      idx;
    logic [7:0]      shreg;
    logic            par;
    logic            din_m, din_s, din_d;

    wire half_done = cnt == CW'(HALF_CLOCKS - 1);
    wire baud_done = cnt == CW'(BAUD_CLOCKS - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {din_m, din_s, din_d} <= 3'b111;
        end else begin
            {din_m, din_s, din_d} <= {din, din_m, din_s};
        end
    end

    // Samples are taken mid-bit: half a period after the start edge, then every full period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            idx         <= '0;
            shreg       <= '0;
            par         <= 1'b0;
            dout        <= '0;
            busy        <= 1'b0;
            data_strobe <= 1'b0;
            rx_error    <= 1'b0;
        end else begin
            data_strobe <= 1'b0;
            cnt         <= cnt + 1'b1;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (din_d && !din_s) begin
                        state <= START;
                        busy  <= 1'b1;
                    end
                end
                START: if (half_done) begin
                    cnt <= '0;
                    idx <= '0;
                    state <= din_s ? IDLE : DATA;
                    busy  <= !din_s;
                end
                DATA: if (baud_done) begin
                    cnt        <= '0;
                    shreg[idx] <= din_s;
                    idx        <= idx + 1'b1;
                    if (idx == 3'd7) state <= PAR;
                end
                PAR: if (baud_done) begin
                    cnt   <= '0;
                    par   <= din_s;
                    state <= STOP;
                end
                STOP: if (baud_done) begin
                    cnt         <= '0;
                    dout        <= shreg;
                    rx_error    <= ((^{shreg, par}) != PARITY) || !din_s;
                    data_strobe <= 1'b1;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx; one odd-parity instance and one fast even-parity instance.
module tb_uart_rx;
    localparam int CLK1 = 2_000_000;
    localparam int BAUD1 = 19_200;
    localparam int B1 = CLK1 / BAUD1;
    localparam int H1 = B1 / 2;
    localparam int CLK2 = 1_500_000;
    localparam int BAUD2 = 115_200;
    localparam int B2 = CLK2 / BAUD2;
    localparam int H2 = B2 / 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       din1 = 1'b1;
    logic       din2 = 1'b1;
    logic [7:0] dout1, dout2;
    logic       busy1, busy2, stb1, stb2, err1, err2;

    int n_checks = 0;
    int n_fail = 0;
    int stb_cnt1 = 0;
    int stb_cnt2 = 0;
    int busy_cyc1 = 0;
    int busy_cyc2 = 0;
    logic [8:0] log1[$];

    always #5 clk = ~clk;

    uart_rx #(.CLK_FREQUENCY(CLK1), .BAUD_RATE(BAUD1), .PARITY(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .din(din1), .dout(dout1),
        .busy(busy1), .data_strobe(stb1), .rx_error(err1));

    uart_rx #(.CLK_FREQUENCY(CLK2), .BAUD_RATE(BAUD2), .PARITY(1'b0)) dut2 (
        .clk(clk), .rst_n(rst_n), .din(din2), .dout(dout2),
        .busy(busy2), .data_strobe(stb2), .rx_error(err2));

    always @(negedge clk) begin
        if (stb1) begin
            stb_cnt1++;
            log1.push_back({err1, dout1});
        end
        if (stb2) stb_cnt2++;
        if (busy1) busy_cyc1++;
        if (busy2) busy_cyc2++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input bit sel, input logic b);
        if (sel) din2 = b;
        else din1 = b;
        wait_clk(sel ? B2 : B1);
    endtask

    task automatic send(input bit sel, input logic [7:0] d, input logic par, input logic stop);
        drive(sel, 1'b0);
        for (int i = 0; i < 8; i++) drive(sel, d[i]);
        drive(sel, par);
        drive(sel, stop);
    endtask

    function automatic logic odd_par(input logic [7:0] d);
        return ~^d;
    endfunction

    initial begin
        int s, b, q;
        #2 rst_n = 1'b0;
        wait_clk(3);
        rst_n = 1'b1;
        wait_clk(5);

        // reset in the middle of line activity
        din1 = 1'b0;
        din2 = 1'b0;
        wait_clk(20);
        rst_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            din1 = i[0];
            din2 = ~i[0];
            #1;
            check("reset_dut1", {dout1, busy1, stb1, err1}, 0);
            check("reset_dut2", {dout2, busy2, stb2, err2}, 0);
            wait_clk(1);
        end
        din1 = 1'b1;
        din2 = 1'b1;
        rst_n = 1'b1;
        wait_clk(B1);

        // good frame 0xA5, odd parity
        s = stb_cnt1;
        b = busy_cyc1;
        send(0, 8'hA5, odd_par(8'hA5), 1'b1);
        wait_clk(5);
        #1;
        check("a5_strobes", stb_cnt1 - s, 1);
        check("a5_dout", dout1, 8'hA5);
        check("a5_err", err1, 0);
        check("a5_busy_cycles", busy_cyc1 - b, H1 + 10 * B1);

        // quarter-bit glitch is rejected
        s = stb_cnt1;
        b = busy_cyc1;
        din1 = 1'b0;
        wait_clk(B1 / 4);
        din1 = 1'b1;
        wait_clk(B1);
        #1;
        check("glitch_strobes", stb_cnt1 - s, 0);
        check("glitch_busy_cycles", busy_cyc1 - b, H1);
        check("glitch_dout", dout1, 8'hA5);

        // parity error, then a good copy
        s = stb_cnt1;
        send(0, 8'h3C, ~odd_par(8'h3C), 1'b1);
        wait_clk(5);
        #1;
        check("badpar_strobes", stb_cnt1 - s, 1);
        check("badpar_dout", dout1, 8'h3C);
        check("badpar_err", err1, 1);
        send(0, 8'h3C, odd_par(8'h3C), 1'b1);
        wait_clk(5);
        #1;
        check("goodpar_strobes", stb_cnt1 - s, 2);
        check("goodpar_err", err1, 0);

        // framing error with the line held low afterwards
        s = stb_cnt1;
        send(0, 8'h55, odd_par(8'h55), 1'b0);
        wait_clk(2 * B1);
        din1 = 1'b1;
        wait_clk(B1);
        #1;
        check("frame_strobes", stb_cnt1 - s, 1);
        check("frame_dout", dout1, 8'h55);
        check("frame_err", err1, 1);
        send(0, 8'h81, odd_par(8'h81), 1'b1);
        wait_clk(5);
        #1;
        check("after_frame_dout", dout1, 8'h81);
        check("after_frame_err", err1, 0);

        // three frames back to back with no idle gap
        q = log1.size();
        s = stb_cnt1;
        send(0, 8'h00, odd_par(8'h00), 1'b1);
        send(0, 8'hFF, odd_par(8'hFF), 1'b1);
        send(0, 8'h7E, odd_par(8'h7E), 1'b1);
        wait_clk(5);
        #1;
        check("b2b_strobes", stb_cnt1 - s, 3);
        if (log1.size() >= q + 3) begin
            check("b2b_first", log1[q], {1'b0, 8'h00});
            check("b2b_second", log1[q+1], {1'b0, 8'hFF});
            check("b2b_third", log1[q+2], {1'b0, 8'h7E});
        end

        // reset during a fourth frame aborts it
        s = stb_cnt1;
        drive(0, 1'b0);
        for (int i = 0; i < 3; i++) drive(0, 1'b1);
        wait_clk(B1 / 2);
        #1;
        check("f4_busy_before_reset", busy1, 1);
        rst_n = 1'b0;
        wait_clk(3);
        rst_n = 1'b1;
        #1;
        check("f4_busy_after_reset", busy1, 0);
        check("f4_dout_after_reset", dout1, 8'h00);
        wait_clk(8 * B1);
        #1;
        check("f4_strobes", stb_cnt1 - s, 0);

        // fast even-parity instance
        s = stb_cnt2;
        b = busy_cyc2;
        send(1, 8'hA5, ^8'hA5, 1'b1);
        wait_clk(5);
        #1;
        check("even_strobes", stb_cnt2 - s, 1);
        check("even_dout", dout2, 8'hA5);
        check("even_err", err2, 0);
        check("even_busy_cycles", busy_cyc2 - b, H2 + 10 * B2);
        send(1, 8'hA5, ~^8'hA5, 1'b1);
        wait_clk(5);
        #1;
        check("even_badpar_strobes", stb_cnt2 - s, 2);
        check("even_badpar_err", err2, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
